// File: rtl/vc_board_pkg.sv
// Board-level constants shared by the switch conditioning path and later board-side blocks.
// Constants only; no logic, latency or backpressure.
package vc_board_pkg;

  localparam int VC_SW_WIDTH     = 8;
  localparam int VC_SYNC_STAGES  = 2;
  localparam int VC_DEB_PRESCALE = 50000;
  localparam int VC_DEB_STABLE   = 4;

endpackage

// File: rtl/vc_debounce_bit.sv
// One switch bit: sync chain, stability counter, clean level and edge pulses.
// Latency SYNC_STAGES plus STABLE sample strobes to accept a level; no backpressure.
module vc_debounce_bit
  import vc_board_pkg::*;
#(
  parameter int SYNC_STAGES = VC_SYNC_STAGES,
  parameter int STABLE      = VC_DEB_STABLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  input  logic sw_in,
  output logic sw_out,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  // Only the last sync stage feeds any decision logic.
  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], sw_in};
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sample) begin
      if (s == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        level_d = s;
        cnt_d   = '0;
        rise_d  = s;
        fall_d  = ~s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign sw_out = level_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: rtl/vc_switch_debounce.sv
// Synchronise and debounce raw switch levels; shared prescaler drives all bits.
// Latency SYNC_STAGES+1 .. SYNC_STAGES+STABLE*PRESCALE+1 cycles; ena=0 freezes everything.
module vc_switch_debounce
  import vc_board_pkg::*;
#(
  parameter int WIDTH       = VC_SW_WIDTH,
  parameter int SYNC_STAGES = VC_SYNC_STAGES,
  parameter int PRESCALE    = VC_DEB_PRESCALE,
  parameter int STABLE      = VC_DEB_STABLE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             tick
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;

  // The sample strobe and the exported tick share one edge, so sw_out moves in the tick cycle.
  always_comb begin
    pre_d  = pre_q;
    tick_d = 1'b0;
    if (ena) begin
      if (pre_q == PRE_LAST) begin
        pre_d  = '0;
        tick_d = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    vc_debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE      (STABLE)
    ) u_bit (
      .clk    (clk),
      .rst_n  (rst_n),
      .sample (tick_d),
      .sw_in  (sw_in[i]),
      .sw_out (sw_out[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

endmodule

// File: doc/vc_switch_debounce.md
Name: vc_switch_debounce

Overview:
- Conditioning stage directly upstream of the CPU's 8-bit dedicated input port on the FPGA board build.
- Takes raw, asynchronous slide-switch/button levels and synchronises them into the CPU clock domain.
- Debounces each bit with a shared sample tick and a per-bit stability counter.
- Presents clean levels plus one-cycle rise/fall event pulses; the clean levels drive the CPU's dedicated input bus.

Parameters:
- WIDTH, 8: number of switch bits.
- SYNC_STAGES, 2: synchroniser flops per bit; minimum 2.
- PRESCALE, 50000: clk cycles per sample tick; minimum 2.
- STABLE, 4: consecutive differing samples required to accept a new level; minimum 1.

Ports:
- clk, input, 1: CPU clock, the same clock that feeds the core.
- rst_n, input, 1: asynchronous active-low reset.
- ena, input, 1: sampling enable; when low, the prescaler and all stability counters freeze.
- sw_in, input, WIDTH: raw asynchronous switch levels.
- sw_out, output, WIDTH: debounced levels, registered.
- rise, output, WIDTH: one-cycle pulse when the matching sw_out bit goes 0->1.
- fall, output, WIDTH: one-cycle pulse when the matching sw_out bit goes 1->0.
- tick, output, 1: one-cycle sample strobe, exported for the test bench and for other slow logic.

Behaviour:
- Clock and reset: single clock domain, clk only. Asynchronous active-low reset on rst_n; every flop uses it.
- Reset values: sync chains 0, prescaler 0, stability counters 0, sw_out 0, rise 0, fall 0, tick 0.
- Synchroniser: sw_in[i] passes through SYNC_STAGES flops. s[i] is the last stage.
- Prescaler:
  - Width is $clog2(PRESCALE); it counts 0..PRESCALE-1 and wraps to 0.
  - tick is registered and is 1 in the cycle after the count equals PRESCALE-1 with ena=1.
  - The first tick after reset release is therefore on cycle PRESCALE, counting the first enabled edge as cycle 1.
- ena handling:
  - ena=0 holds the prescaler count.
  - tick is forced 0 while ena=0.
  - Stability counters hold.
  - sw_out, rise and fall hold or return to 0 as defined below.
- Per-bit stability counter cnt[i]:
  - Width is $clog2(STABLE+1); saturation is never reached because acceptance resets the counter.
  - Counter updates happen only in cycles where tick=1.
  - If s[i]==sw_out[i]: cnt[i] <= 0. Any agreeing sample cancels a pending change.
  - If s[i]!=sw_out[i] and cnt[i]==STABLE-1: sw_out[i] <= s[i], cnt[i] <= 0.
  - If s[i]!=sw_out[i] and cnt[i]<STABLE-1: cnt[i] <= cnt[i]+1.
- Events:
  - rise[i] and fall[i] are registered and asserted in the same cycle sw_out[i] takes its new value.
  - Each pulse lasts exactly 1 cycle.
  - rise[i] and fall[i] are never both 1.
  - Bits are independent, so several bits may change on the same tick.
- Latency: from a sw_in edge to sw_out, at least SYNC_STAGES+1 and at most SYNC_STAGES + STABLE*PRESCALE + 1 cycles.
- Glitch rejection: any pulse lasting fewer than (STABLE-1)*PRESCALE+1 cycles is never accepted.
- Reset mid-debounce: asynchronous return to all-zero. After release, a held input must re-qualify with the full STABLE count.
- Metastability: no logic reads sw_in before the last sync stage.

Decomposition:
- Shared package vc_board_pkg:
  - Default constants VC_SW_WIDTH=8, VC_SYNC_STAGES=2, VC_DEB_PRESCALE=50000, VC_DEB_STABLE=4.
  - Later board-side blocks reuse these constants.
- One natural sub-module: vc_debounce_bit. It contains the sync chain, stability counter, level and edge registers, and is instantiated WIDTH times under a generate loop.
- The prescaler and tick stay in the parent.

Test Plan (PRESCALE=4, STABLE=3, SYNC_STAGES=2 unless stated):
- Reset then hold sw_in=8'h00 for 100 cycles -> sw_out=8'h00, rise=fall=0 throughout; tick pulses at cycles 4, 8, 12, ...
- Set sw_in=8'h01 at cycle 0 after reset release and hold -> sw_out[0]=1 and rise[0]=1 for exactly one cycle at the third tick that sees s[0]=1 (cycle 12); no other bit moves.
- From sw_out=8'h01, drive sw_in[0]=0 for 6 cycles, then back to 1 -> sw_out stays 8'h01, no fall pulse; cnt[0] returns to 0.
- Change sw_in from 8'h0F to 8'hF0 on one edge -> bits 0-3 fall and bits 4-7 rise in the same cycle; sw_out=8'hF0.
- Drop ena to 0 for 20 cycles during a pending change -> no tick, cnt frozen; after ena=1 the change completes after the remaining ticks only.
- Assert rst_n=0 for 1 cycle after two qualifying ticks -> all outputs 0 immediately; the held input needs 3 fresh ticks to reach sw_out.
